// File: rtl/ram_chk_pkg.sv
// Shared types and default widths for the RAM read-back checker.
// Status encoding is what the ILA/LEDs decode, so the values are fixed.
package ram_chk_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } status_t;

    // Tag layout at the default widths; the top re-declares it at its own widths.
    typedef struct packed {
        logic                  valid;
        logic                  known;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] exp;
    } tag_t;

endpackage

// File: rtl/ram_shadow.sv
// Shadow copy of the RAM: one write port, one combinational read port,
// plus a per-address "written since reset" bit.
module ram_shadow
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_known
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  known;

    // Data has no reset; only the known bits decide whether a read is checked.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        known          <= '0;
        else if (wr_en) known[wr_addr] <= 1'b1;
    end

    assign rd_data  = mem[rd_addr];
    assign rd_known = known[rd_addr];

endmodule

// File: rtl/ram_rd_chk.sv
// Snoops a single-port RAM, predicts each read from a shadow copy and checks
// douta RD_LAT cycles later; reports status, saturating counters, first error.
module ram_rd_chk
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] douta,
    input  logic              clr,
    output logic              chk_vld,
    output logic              chk_err,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  unk_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got
);

    typedef struct packed {
        logic              valid;
        logic              known;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } tag_p_t;

    logic              wr_ev;
    logic              rd_ev;
    logic [DATA_W-1:0] sh_data;
    logic              sh_known;
    tag_p_t            tag_in;
    tag_p_t            tag_q [RD_LAT];
    tag_p_t            tag_out;
    logic              cmp;
    logic              mism;
    logic              unk;
    status_t           state_q;
    status_t           state_d;

    assign wr_ev = ram_en & rw;
    assign rd_ev = ram_en & ~rw;

    ram_shadow #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ev),
        .wr_addr  (ram_addr),
        .wr_data  (ram_wr_data),
        .rd_addr  (ram_addr),
        .rd_data  (sh_data),
        .rd_known (sh_known)
    );

    // Expectation is frozen at issue, so later writes cannot disturb it.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd_ev;
        tag_in.known = rd_ev & sh_known;
        tag_in.addr  = ram_addr;
        tag_in.exp   = sh_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[RD_LAT-1];
    assign cmp     = tag_out.valid & tag_out.known;
    assign unk     = tag_out.valid & ~tag_out.known;
    assign mism    = cmp & (douta != tag_out.exp);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr)                         state_d = IDLE;
        else if (mism)                   state_d = FAIL;
        else if (cmp && state_q == IDLE) state_d = PASS;
    end

    assign status = state_q;

    // clr wins over an exiting tag: that result is dropped along with the stats.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chk_vld        <= 1'b0;
            chk_err        <= 1'b0;
            rd_cnt         <= '0;
            err_cnt        <= '0;
            unk_cnt        <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
        end else begin
            chk_vld <= cmp;
            chk_err <= mism;
            if (cmp && rd_cnt != '1)   rd_cnt  <= rd_cnt + 1'b1;
            if (mism && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (unk && unk_cnt != '1)  unk_cnt <= unk_cnt + 1'b1;
            if (mism && err_cnt == '0) begin
                first_err_addr <= tag_out.addr;
                first_err_exp  <= tag_out.exp;
                first_err_got  <= douta;
            end
        end
    end

endmodule
